// File: rtl/unroller.sv
`default_nettype none
// ============================================================================
// Module   : unroller
// Purpose  : Gathers ROLL_NUM-element beats from a narrow valid/ready stream
//            into one registered NUM-element vector (inverse of the roller).
//            Beat k fills elements k*ROLL_NUM .. k*ROLL_NUM+ROLL_NUM-1.
// Option   : UNROLLER_LAST_EN adds data_in_last to close a vector early;
//            lanes that were not written read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module unroller #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM        = 8,
   parameter int ROLL_NUM   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM-1:0],
   input  logic                  data_in_valid,
`ifdef UNROLLER_LAST_EN
   input  logic                  data_in_last,
`endif
   output logic                  data_in_ready,
   output logic [DATA_WIDTH-1:0] data_out [NUM-1:0],
   output logic                  data_out_valid,
   input  logic                  data_out_ready
);

   localparam int c_CYCLES = NUM / ROLL_NUM;
   localparam int c_CNT_W  = (c_CYCLES > 1) ? $clog2(c_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_CYCLES - 1);

   // Reject geometries where the vector is not a whole number of beats.
   generate
      if ((NUM % ROLL_NUM) != 0) begin : g_bad_cfg
         $error("unroller: NUM (%0d) must be a multiple of ROLL_NUM (%0d)", NUM, ROLL_NUM);
      end
   endgenerate

   logic [c_CNT_W-1:0] cnt_q;
   logic [c_CNT_W-1:0] cnt_d;
   logic               out_valid_q;
   logic               out_valid_d;

   logic w_final_slot;
   logic w_done_beat;
   logic w_accept;
   logic w_complete;

   assign w_final_slot = (cnt_q == c_LAST_BEAT);

`ifdef UNROLLER_LAST_EN
   assign w_done_beat = w_final_slot || data_in_last;
`else
   assign w_done_beat = w_final_slot;
`endif

   // Only a completing beat can be blocked, and only by a full, non-draining
   // output register; this is the single combinational path out_ready->in_ready.
   assign data_in_ready = !w_done_beat || !out_valid_q || data_out_ready;
   assign w_accept      = data_in_valid && data_in_ready;
   assign w_complete    = w_accept && w_done_beat;
   assign data_out_valid = out_valid_q;

   // Next beat index: advance per accepted beat, restart after a completion.
   always_comb begin
      cnt_d = cnt_q;
      if (w_accept) begin
         if (w_done_beat) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
         end
      end
   end

   // Output occupancy: set on completion (wins over a same-cycle drain).
   always_comb begin
      out_valid_d = out_valid_q;
      if (w_complete) begin
         out_valid_d = 1'b1;
      end else if (out_valid_q && data_out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Beat counter and output-valid state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   // One accumulator element and one output element per vector position.
   generate
      for (genvar i = 0; i < NUM; i++) begin : g_elem
         localparam logic [c_CNT_W-1:0] c_BEAT = c_CNT_W'(i / ROLL_NUM);
         localparam int                 c_LANE = i % ROLL_NUM;

         logic [DATA_WIDTH-1:0] acc_q;
         logic [DATA_WIDTH-1:0] out_q;
         logic                  w_hit;
         logic [DATA_WIDTH-1:0] w_merged;

         // This element is written by the beat currently being accepted.
         assign w_hit    = w_accept && (cnt_q == c_BEAT);
         // Accumulated value with the completing beat folded in.
         assign w_merged = w_hit ? data_in[c_LANE] : acc_q;
         assign data_out[i] = out_q;

         // Accumulate lanes; clear on completion so a short vector pads zeros.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               acc_q <= '0;
               out_q <= '0;
            end else begin
               if (w_complete) begin
                  acc_q <= '0;
                  out_q <= w_merged;
               end else if (w_hit) begin
                  acc_q <= data_in[c_LANE];
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_unroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_unroller
// Purpose  : Self-checking bench for unroller (NUM=8/ROLL_NUM=2 instance with
//            a queue-based reference model, plus a NUM=ROLL_NUM=4 instance).
//            Honours UNROLLER_LAST_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unroller;
   localparam int DW   = 16;
   localparam int NUM  = 8;
   localparam int ROLL = 2;
   localparam int N4   = 4;
   localparam int VW   = NUM * DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [DW-1:0] din [ROLL-1:0];
   logic          din_valid;
   logic          din_ready;
   logic          din_last;
   logic [DW-1:0] dout [NUM-1:0];
   logic          dout_valid;
   logic          dout_ready;

   logic [DW-1:0] din4 [N4-1:0];
   logic          din4_valid;
   logic          din4_ready;
   logic          din4_last;
   logic [DW-1:0] dout4 [N4-1:0];
   logic          dout4_valid;
   logic          dout4_ready;

   unroller #(.DATA_WIDTH(DW), .NUM(NUM), .ROLL_NUM(ROLL)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (din),
      .data_in_valid  (din_valid),
`ifdef UNROLLER_LAST_EN
      .data_in_last   (din_last),
`endif
      .data_in_ready  (din_ready),
      .data_out       (dout),
      .data_out_valid (dout_valid),
      .data_out_ready (dout_ready)
   );

   unroller #(.DATA_WIDTH(DW), .NUM(N4), .ROLL_NUM(N4)) u_dut4 (
      .clk            (clk),
      .rst            (rst),
      .data_in        (din4),
      .data_in_valid  (din4_valid),
`ifdef UNROLLER_LAST_EN
      .data_in_last   (din4_last),
`endif
      .data_in_ready  (din4_ready),
      .data_out       (dout4),
      .data_out_valid (dout4_valid),
      .data_out_ready (dout4_ready)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [VW-1:0] pack8(input logic [DW-1:0] a [NUM-1:0]);
      logic [VW-1:0] r = '0;
      for (int i = 0; i < NUM; i++) r[i*DW +: DW] = a[i];
      return r;
   endfunction

   function automatic logic [VW-1:0] pack4(input logic [DW-1:0] a [N4-1:0]);
      logic [VW-1:0] r = '0;
      for (int i = 0; i < N4; i++) r[i*DW +: DW] = a[i];
      return r;
   endfunction

   // Reference model: elements collected so far and the vector on the output.
   logic [DW-1:0] pend [$];
   logic [VW-1:0] exp_q [$];

   // One clock: apply inputs, check outputs against the model, advance model.
   task automatic tick(input bit v, input int unsigned b0, input int unsigned b1,
                       input bit ordy, input bit last);
      bit            exp_v;
      bit            exp_r;
      bit            fin;
      logic [VW-1:0] vec;
      din_valid  = v;
      din[0]     = DW'(b0);
      din[1]     = DW'(b1);
      dout_ready = ordy;
      din_last   = last;
      #1;
      exp_v = (exp_q.size() != 0);
      fin   = (pend.size() == NUM - ROLL);
`ifdef UNROLLER_LAST_EN
      fin   = fin || last;
`endif
      exp_r = !(fin && exp_v && !ordy);
      check_eq("out_valid", VW'(dout_valid), VW'(exp_v));
      check_eq("in_ready", VW'(din_ready), VW'(exp_r));
      if (exp_v) check_eq("out_data", pack8(dout), exp_q[0]);
      if (exp_v && ordy) void'(exp_q.pop_front());
      if (v && exp_r) begin
         pend.push_back(DW'(b0));
         pend.push_back(DW'(b1));
`ifdef UNROLLER_LAST_EN
         if (last) while (pend.size() < NUM) pend.push_back('0);
`endif
         if (pend.size() == NUM) begin
            vec = '0;
            for (int i = 0; i < NUM; i++) vec[i*DW +: DW] = pend[i];
            exp_q.push_back(vec);
            pend.delete();
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=done");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VW-1:0] prev4;
      logic [VW-1:0] cur4;
      rst = 1'b0;
      din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
      din[0] = '0; din[1] = '0;
      din4_valid = 1'b0; din4_last = 1'b0; dout4_ready = 1'b1;
      for (int j = 0; j < N4; j++) din4[j] = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", VW'(dout_valid), VW'(0));
      check_eq("rst_data", pack8(dout), '0);
      rst = 1'b1;

      // Single vector, ready high.
      for (int k = 0; k < 4; k++) tick(1, 2*k+1, 2*k+2, 1, 0);
      repeat (2) tick(0, 0, 0, 1, 0);

      // Back-to-back vectors.
      for (int k = 0; k < 8; k++) tick(1, 2*k+1, 2*k+2, 1, 0);
      repeat (2) tick(0, 0, 0, 1, 0);

      // Output held while the next vector stalls on its final beat.
      for (int k = 0; k < 4; k++) tick(1, 2*k+1, 2*k+2, 0, 0);
      for (int k = 4; k < 7; k++) tick(1, 2*k+1, 2*k+2, 0, 0);
      repeat (2) tick(1, 15, 16, 0, 0);
      tick(1, 15, 16, 1, 0);
      repeat (2) tick(0, 0, 0, 1, 0);

      // Asynchronous reset mid-vector with an occupied output.
      for (int k = 0; k < 4; k++) tick(1, 2*k+1, 2*k+2, 0, 0);
      tick(1, 1, 2, 0, 0);
      tick(1, 3, 4, 0, 0);
      din_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_eq("async_rst_valid", VW'(dout_valid), VW'(0));
      check_eq("async_rst_data", pack8(dout), '0);
      pend.delete();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      for (int k = 2; k < 6; k++) tick(1, 2*k+1, 2*k+2, 1, 0);
      repeat (2) tick(0, 0, 0, 1, 0);

`ifdef UNROLLER_LAST_EN
      // Early close leaves the unwritten lanes zero.
      tick(1, 1, 2, 1, 0);
      tick(1, 3, 4, 1, 1);
      for (int k = 2; k < 6; k++) tick(1, 2*k+1, 2*k+2, 1, 0);
      repeat (2) tick(0, 0, 0, 1, 0);
`endif

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         bit rl;
         rl = 1'b0;
`ifdef UNROLLER_LAST_EN
         rl = ($urandom_range(0, 9) == 0);
`endif
         tick($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 9) < 6, rl);
      end
      din_valid = 1'b0;
      repeat (3) tick(0, 0, 0, 1, 0);

      // NUM == ROLL_NUM: every beat is a vector, one cycle later.
      prev4 = '0;
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < N4; j++) din4[j] = DW'($urandom);
         din4_valid = 1'b1;
         #1;
         cur4 = '0;
         for (int j = 0; j < N4; j++) cur4[j*DW +: DW] = din4[j];
         check_eq("n4_ready", VW'(din4_ready), VW'(1));
         if (k > 0) begin
            check_eq("n4_valid", VW'(dout4_valid), VW'(1));
            check_eq("n4_data", pack4(dout4), prev4);
         end
         prev4 = cur4;
         @(negedge clk);
      end
      din4_valid = 1'b0;
      #1;
      check_eq("n4_valid_last", VW'(dout4_valid), VW'(1));
      check_eq("n4_data_last", pack4(dout4), prev4);
      @(negedge clk);
      #1;
      check_eq("n4_valid_idle", VW'(dout4_valid), VW'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/unroller.md
Name: unroller

Overview:
- Inverse of the roller: gathers ROLL_NUM-element beats from a narrow valid/ready stream into one NUM-element vector.
- Emits the vector after CYCLES = NUM/ROLL_NUM accepted beats.
- Sits after a roller or a narrow compute stage, e.g. a folded conv/linear output, to restore the full-width parallel interface.
- Sustains one beat per cycle with back-to-back vectors; the output is registered.

Parameters:
- DATA_WIDTH, 16, bit width of one element.
- NUM, 8, elements per output vector. NUM % ROLL_NUM == 0 is required; violation is a $error at elaboration.
- ROLL_NUM, 2, elements per input beat. CYCLES = NUM/ROLL_NUM.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- data_in  in  DATA_WIDTH x ROLL_NUM (unpacked [ROLL_NUM-1:0])  input beat.
- data_in_valid  in  1  beat valid.
- data_in_ready  out  1  beat accepted when valid && ready.
- data_out  out  DATA_WIDTH x NUM (unpacked [NUM-1:0])  assembled vector, registered.
- data_out_valid  out  1  vector valid, registered.
- data_out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst low, async):
  - beat counter = 0, accumulator = 0, output register = 0, data_out_valid = 0.
  - Clearing is immediate and mid-vector beats are discarded.
  - data_in_ready is 1 whenever rst is deasserted and the output is empty.
- Counter: width max(1,$clog2(CYCLES)), range 0..CYCLES-1.
  - Increments on each accepted beat.
  - Wraps to 0 on the accepted beat where counter == CYCLES-1 (the final beat).
- Placement: accepted beat k drives elements k*ROLL_NUM+j for j = 0..ROLL_NUM-1.
  - data_in[j] maps to vector[k*ROLL_NUM+j], so the first beat fills the lowest indices (roller order).
- Final beat handling:
  - Output register loads the accumulator contents with the final beat merged in combinationally.
  - data_out_valid = 1 the next cycle, giving latency 1 cycle from final beat acceptance.
  - The accumulator is cleared to 0 on completion.
- Output handshake:
  - data_out_valid stays 1 and data_out is held stable until data_out_valid && data_out_ready.
  - After that handshake data_out_valid falls unless a new vector completes in the same cycle.
- Ready logic (combinational): data_in_ready = (counter != CYCLES-1) || !data_out_valid || data_out_ready.
  - Non-final beats are always accepted while an older vector waits.
  - The final beat stalls only if the output is occupied and not draining.
- Simultaneous output drain and final beat: the output reloads with the new vector and data_out_valid stays 1, with no bubble.
- data_in_valid low: counter and accumulator hold; no timeout.
- CYCLES == 1 (NUM == ROLL_NUM): every accepted beat is final, giving a registered pipeline stage with a single-entry output.
- data_in while not (valid && ready) is ignored and never written.
- No combinational path data_in -> data_out. The only combinational path is data_out_ready -> data_in_ready.

Optional Feature:
- Macro UNROLLER_LAST_EN.
- Defined:
  - Adds input port data_in_last (1 bit), sampled with data_in.
  - An accepted beat with last = 1 is treated as final regardless of counter.
  - Lanes not yet written stay 0 (accumulator cleared on completion guarantees it); counter resets to 0.
  - Ready uses (counter == CYCLES-1 || data_in_last) in place of (counter == CYCLES-1).
  - last = 1 on the CYCLES-th beat is identical to a normal completion.
- Undefined: port absent; vectors complete only after exactly CYCLES beats.

Test Plan:
- NUM=8, ROLL_NUM=2, data_out_ready=1. Beats {1,2},{3,4},{5,6},{7,8} on 4 consecutive cycles -> data_out = {1..8} (index 0 = 1), valid high exactly 1 cycle, 1 cycle after the 4th beat.
- Back-to-back vectors {1..8} then {9..16}, ready=1 -> two valid outputs 4 cycles apart, data_in_ready never drops.
- Hold data_out_ready=0 after the first vector completes, feed 4 more beats:
  - beats 1-3 accepted, data_in_ready = 0 on beat 4, data_out held at {1..8};
  - raise ready -> same-cycle drain + accept, next data_out = {9..16}, valid never drops.
- Reset low after 2 beats {1,2},{3,4} -> valid = 0 immediately, then beats {5,6}..{11,12} -> data_out = {5..12} with no stale data.
- NUM=ROLL_NUM=4: beat {A,B,C,D} -> data_out {A,B,C,D} next cycle; full throughput with ready=1.
- UNROLLER_LAST_EN: beats {1,2},{3,4} with last=1 on the second -> data_out = {1,2,3,4,0,0,0,0}; next 4 beats assemble normally.
